// File: rtl/instruction_memory_loader.sv
// rtl/instruction_memory_loader.sv - byte-serial program loader and combinational instruction fetch memory
module instruction_memory_loader #(
  parameter int N     = 24,
  parameter int DEPTH = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N-1:0]               address,
  output logic [N-1:0]               instruction,
  input  logic                       load_start,
  input  logic                       load_valid,
  input  logic [7:0]                 load_byte,
  input  logic                       load_last,
  output logic                       load_ready,
  output logic                       mem_ready,
  output logic [$clog2(DEPTH):0]     word_count,
  output logic                       load_error
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_READY
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      bc_q, bc_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW:0]     word_count_q, word_count_d;
  logic            load_error_q, load_error_d;
  logic [15:0]     hold_q, hold_d;

  logic            accept;
  logic            mem_we;
  logic [N-1:0]    mem_wdata;
  logic [N-1:0]    mem [DEPTH];

  logic [AW-1:0]   rd_idx;
  logic            rd_hit;

  // Load FSM: restart on load_start, otherwise assemble accepted bytes into words
  always_comb begin
    state_d      = state_q;
    bc_d         = bc_q;
    wptr_d       = wptr_q;
    word_count_d = word_count_q;
    load_error_d = load_error_q;
    hold_d       = hold_q;
    mem_we       = 1'b0;
    mem_wdata    = {hold_q, load_byte};
    // load_start takes priority, so a byte presented in the same cycle is dropped
    accept       = (state_q == S_LOAD) && load_valid && !load_start;

    if (load_start) begin
      state_d      = S_LOAD;
      bc_d         = 2'd0;
      wptr_d       = '0;
      word_count_d = '0;
      load_error_d = 1'b0;
      hold_d       = '0;
    end else if (accept) begin
      case (bc_q)
        2'd0: begin
          hold_d[15:8] = load_byte;
          bc_d         = 2'd1;
        end
        2'd1: begin
          hold_d[7:0] = load_byte;
          bc_d        = 2'd2;
        end
        default: begin
          bc_d = 2'd0;
          // A full array discards further words but keeps consuming bytes until load_last
          if (word_count_q == FULL_COUNT) begin
            load_error_d = 1'b1;
          end else begin
            mem_we       = 1'b1;
            wptr_d       = wptr_q + 1'b1;
            word_count_d = word_count_q + 1'b1;
          end
        end
      endcase
      if (load_last) begin
        state_d = S_READY;
        if (bc_q != 2'd2) begin
          load_error_d = 1'b1;
        end
      end
    end
  end

  // Control state register; the instruction array itself is never reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      bc_q         <= 2'd0;
      wptr_q       <= '0;
      word_count_q <= '0;
      load_error_q <= 1'b0;
      hold_q       <= '0;
    end else begin
      state_q      <= state_d;
      bc_q         <= bc_d;
      wptr_q       <= wptr_d;
      word_count_q <= word_count_d;
      load_error_q <= load_error_d;
      hold_q       <= hold_d;
    end
  end

  // Instruction array write port, written when the third byte of a word is accepted
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wptr_q] <= mem_wdata;
    end
  end

  // Fetch read path: only aligned, in-range, loaded words are visible; everything else is NOP
  always_comb begin
    rd_idx      = address[AW+1:2];
    rd_hit      = (state_q == S_READY) &&
                  (address[1:0] == 2'b00) &&
                  ({1'b0, rd_idx} < word_count_q) &&
                  (address[N-1:AW+2] == '0);
    instruction = rd_hit ? mem[rd_idx] : '0;
  end

  assign load_ready = (state_q == S_LOAD);
  assign mem_ready  = (state_q == S_READY);
  assign word_count = word_count_q;
  assign load_error = load_error_q;

endmodule
